// File: rtl/grey_ring_mod.sv
// ---------------------------------------------------------------------------
// grey_ring_mod
//   Parametrised ring-Gray digit counter. Counts modulo M = 2*pWIDTH in a
//   ring code where neighbouring positions (including the wrap) differ in a
//   single bit. Usable as one digit of a counter chain or as a prescaler.
//
//   Code for position k (j = k/2):
//     k even : bits j-1 and j set (indices mod pWIDTH)
//     k odd  : bit j set
//
// Ports
//   i_clk       clock, all state updates on posedge
//   i_rst       synchronous active-high reset
//   i_en        step enable
//   i_dir       1 = up, 0 = down (only looked at while stepping)
//   i_load      synchronous load strobe (beats i_en)
//   i_load_val  binary position to load
//   o_cnt       ring-code count
//   o_bin       binary position, aligned with o_cnt
//   o_wrap      one-cycle pulse after an M-1 -> 0 or 0 -> M-1 step
//   o_clk_div   high while position >= pWIDTH (50% duty when free-running)
//   o_err       one-cycle pulse after illegal-code recovery or bad load
// ---------------------------------------------------------------------------
module grey_ring_mod #(
  parameter  int pWIDTH = 5,
  localparam int pBIN_W = $clog2(2 * pWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic              i_load,
  input  logic [pBIN_W-1:0] i_load_val,
  output logic [pWIDTH-1:0] o_cnt,
  output logic [pBIN_W-1:0] o_bin,
  output logic              o_wrap,
  output logic              o_clk_div,
  output logic              o_err
);

  localparam int                M      = 2 * pWIDTH;
  localparam logic [pBIN_W:0]   M_EXT  = (pBIN_W + 1)'(M);
  localparam logic [pBIN_W-1:0] LAST   = pBIN_W'(M - 1);
  localparam logic [pBIN_W-1:0] HALF   = pBIN_W'(pWIDTH);

  // Ring code of a binary position.
  function automatic logic [pWIDTH-1:0] code_of(input logic [pBIN_W-1:0] k);
    logic [pWIDTH-1:0] c;
    int                j;
    j = int'(k) / 2;
    for (int b = 0; b < pWIDTH; b++) begin
      c[b] = (b == j) || (!k[0] && (b == (j + pWIDTH - 1) % pWIDTH));
    end
    return c;
  endfunction

  // The binary position is the sequencing state. At pWIDTH=2 the code is
  // not unique (positions 0 and 2 both read 11), so the code register alone
  // cannot determine the successor; it is only checked for legality.
  logic [pBIN_W-1:0] r_pos;
  logic [pWIDTH-1:0] r_cnt;
  logic              r_wrap;
  logic              r_clk_div;
  logic              r_err;

  logic [pBIN_W-1:0] w_next_pos;
  logic              w_wrap_nxt;
  logic              w_err_nxt;
  logic              w_legal;
  logic              w_load_ok;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_legal = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (r_cnt == code_of(pBIN_W'(k))) w_legal = 1'b1;
    end

    w_load_ok  = {1'b0, i_load_val} < M_EXT;
    w_next_pos = r_pos;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;

    if (i_load) begin
      if (w_load_ok) begin
        w_next_pos = i_load_val;
      end else begin
        w_next_pos = '0;
        w_err_nxt  = 1'b1;
      end
    end else if (!w_legal) begin
      // Corrupted code: resynchronise to position 0 whatever en/dir say.
      w_next_pos = '0;
      w_err_nxt  = 1'b1;
    end else if (i_en) begin
      if (i_dir) begin
        if (r_pos == LAST) begin
          w_next_pos = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_next_pos = r_pos + 1'b1;
        end
      end else begin
        if (r_pos == '0) begin
          w_next_pos = LAST;
          w_wrap_nxt = 1'b1;
        end else begin
          w_next_pos = r_pos - 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos     <= '0;
      r_cnt     <= code_of('0);
      r_wrap    <= 1'b0;
      r_clk_div <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pos     <= w_next_pos;
      r_cnt     <= code_of(w_next_pos);
      r_wrap    <= w_wrap_nxt;
      r_clk_div <= (w_next_pos >= HALF);
      r_err     <= w_err_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_bin     = r_pos;
  assign o_wrap    = r_wrap;
  assign o_clk_div = r_clk_div;
  assign o_err     = r_err;

endmodule

// File: doc/grey_ring_mod.md
Name: grey_ring_mod

Overview:
- Parametrised successor to the fixed decade ring-Gray counter.
- Counts modulo 2*pWIDTH in a single-bit-change ring code.
- Adds enable, up/down direction, synchronous binary load, a binary readback and a registered wrap pulse for cascading digits.
- Adds illegal-code recovery and a registered ~50% duty divided clock; used as a digit/prescaler stage in counter and clock-divider chains.

Parameters:
- pWIDTH, 5, code width in bits; modulus M = 2*pWIDTH; legal range 2..16.
- pBIN_W (localparam), $clog2(2*pWIDTH), width of the binary count/load value (4 at default).

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  1  count enable; step one position per cycle when high.
- i_dir  input  1  direction; 1 = up, 0 = down; sampled only when stepping.
- i_load  input  1  synchronous load strobe.
- i_load_val  input  pBIN_W  binary position to load.
- o_cnt  output  pWIDTH  ring-code count (registered).
- o_bin  output  pBIN_W  binary equivalent of o_cnt (registered, same cycle as o_cnt).
- o_wrap  output  1  one-cycle pulse on the cycle after the count wraps.
- o_clk_div  output  1  divided clock, high while position >= pWIDTH.
- o_err  output  1  one-cycle pulse: illegal code recovered or out-of-range load.

Behaviour:
- Code for position k, 0 <= k < M, with j = k/2:
  - k even: bits j-1 and j set, indices mod pWIDTH (k=0 sets bit pWIDTH-1 and bit 0).
  - k odd: only bit j set.
- At pWIDTH=5 the sequence is 10001, 00001, 00011, 00010, 00110, 00100, 01100, 01000, 11000, 10000.
- Adjacent positions, including the wrap M-1 <-> 0, differ in exactly one bit.
- Reset values: o_cnt = code(0), o_bin = 0, o_wrap = 0, o_clk_div = 0, o_err = 0.
- Update priority per posedge: i_rst > i_load > i_en > hold.
- Load:
  - If i_load_val < M: position <= i_load_val. Load takes effect even when i_en = 0, and i_en/i_dir are ignored that cycle.
  - If i_load_val >= M: position <= 0 and o_err = 1 next cycle.
  - o_wrap = 0 on any load.
- Step (i_en = 1, no load):
  - Up: k -> k+1, and M-1 -> 0.
  - Down: k -> k-1, and 0 -> M-1.
  - Latency is 1 cycle; o_cnt and o_bin change together.
- Hold (i_en = 0, no load): all state holds. o_wrap and o_err are 0.
- o_wrap is registered: 1 for exactly the cycle following an up step M-1 -> 0 or a down step 0 -> M-1, otherwise 0. A downstream digit uses it as its i_en.
- o_clk_div is registered from the next position: o_clk_div <= (next position >= pWIDTH). It is low for positions 0..pWIDTH-1 and high for pWIDTH..M-1 in both directions and after a load, giving exactly 50% duty when free-running.
- Illegal code:
  - If o_cnt holds any pattern outside the M legal codes on a cycle with no reset and no load, the next state is position 0 regardless of i_en/i_dir.
  - o_err pulses on the following cycle and o_wrap = 0.
  - o_bin tracks the ring state; its value while the code is illegal is don't-care.
- Reset mid-count: state and all outputs return to reset values on the next edge; pending pulses are cleared.

Test Plan:
- Reset then i_en=1, i_dir=1 for 12 cycles (pWIDTH=5) -> o_cnt 10001, 00001, 00011, 00010, 00110, 00100, 01100, 01000, 11000, 10000, 10001, 00001. o_bin 0..9,0,1. o_wrap high only the cycle o_bin returns to 0. o_clk_div high exactly while o_bin in 5..9. Exactly one bit changes per step.
- Free-run up 40 cycles -> o_clk_div period 10 cycles, 5 high / 5 low; o_wrap period 10.
- Down from 0: i_dir=0, i_en=1 -> o_bin 9,8,7...; o_wrap pulses with o_bin=9 after 0->9; o_clk_div high for 9..5.
- i_load=1, i_load_val=7, i_en=0 -> next cycle o_bin=7, o_cnt=01000, o_clk_div=1, o_wrap=0. Then load 12 -> o_bin=0, o_cnt=10001, o_err one-cycle pulse.
- Force o_cnt=10101 (illegal), release, i_en=0 -> next cycle o_cnt=10001, o_err=1 for one cycle.
- i_rst asserted with i_load=1 mid-count at o_bin=6 -> next cycle all reset values. Then i_en=0 for 5 cycles -> outputs held constant.
- Repeat the up and down sequences with pWIDTH=2 (M=4: 11,01,11? no: 11, 01, 11...) and pWIDTH=8 (M=16, pBIN_W=4): sequence and wrap correct, one-bit changes hold, o_clk_div 50% duty. For pWIDTH=2 the legal codes are 11, 01, 11, 10 by the formula, so verify the generated table and adjacency property explicitly.
